// File: rtl/irq_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : irq_dispatcher_if
// Description : Handshake bundle between the priority encoder / interrupt
//               consumer and irq_dispatcher.
//               master : dispatcher side (drives irq, vector, clear, busy,
//                        timeout; receives enc_out, enc_valid, ack)
//               slave  : environment side (encoder, consumer, request latch)
//               Optional macro IRQ_SERVICE_COUNT_EN adds the 8-bit
//               'serviced' count output.
// Revision    : 1.0 - initial release
// ============================================================================
interface irq_dispatcher_if;
  logic [1:0] enc_out;    // encoded index of highest-priority request
  logic       enc_valid;  // at least one request active
  logic       ack;        // consumer acknowledge
  logic       irq;        // held interrupt request
  logic [1:0] vector;     // index being serviced
  logic [3:0] clear;      // one-hot clear pulse to the request latch
  logic       busy;       // high outside IDLE
  logic       timeout;    // request abandoned pulse
`ifdef IRQ_SERVICE_COUNT_EN
  logic [7:0] serviced;   // saturating count of acknowledged interrupts
`endif

  modport master (
    input  enc_out, enc_valid, ack,
    output irq, vector, clear, busy, timeout
`ifdef IRQ_SERVICE_COUNT_EN
    , output serviced
`endif
  );

  modport slave (
    output enc_out, enc_valid, ack,
    input  irq, vector, clear, busy, timeout
`ifdef IRQ_SERVICE_COUNT_EN
    , input serviced
`endif
  );
endinterface
`default_nettype wire

// File: rtl/irq_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : irq_dispatcher
// Description : Converts a valid encoded request from a 4-input priority
//               encoder into a held interrupt (irq + vector), waits for an
//               acknowledge, then pulses a one-hot clear back to the request
//               latch. Requests not acknowledged within TIMEOUT cycles are
//               abandoned with a one-cycle timeout pulse.
// Ports       : clock  - system clock, rising edge
//               reset  - asynchronous active-high reset
//               bus    - irq_dispatcher_if.master (enc_out, enc_valid, ack in;
//                        irq, vector, clear, busy, timeout out)
// Parameters  : TIMEOUT - cycles irq is held without ack (1 .. 2**CW-1)
//               CW      - wait counter width
// Options     : IRQ_SERVICE_COUNT_EN - adds 8-bit saturating 'serviced' count
// Revision    : 1.0 - initial release
// ============================================================================
module irq_dispatcher #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  wire logic       clock,
  input  wire logic       reset,
  irq_dispatcher_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_irq, w_irq;
  logic [1:0]    r_vector, w_vector;
  logic [3:0]    r_clear, w_clear;
  logic          r_busy, w_busy;
  logic          r_timeout, w_timeout;

  // State and every output are registered together, so outputs never have
  // a combinational path from the inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_irq     <= 1'b0;
      r_vector  <= 2'b00;
      r_clear   <= 4'b0000;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_irq     <= w_irq;
      r_vector  <= w_vector;
      r_clear   <= w_clear;
      r_busy    <= w_busy;
      r_timeout <= w_timeout;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_irq     = r_irq;
    w_vector  = r_vector;
    w_clear   = 4'b0000;   // clear and timeout are single-cycle pulses
    w_timeout = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.enc_valid) begin
          w_vector = bus.enc_out;
          w_irq    = 1'b1;
          w_cnt    = '0;
          w_state  = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // ack takes precedence over an expiring counter
        if (bus.ack) begin
          w_irq   = 1'b0;
          w_clear = 4'b0001 << r_vector;
          w_state = ST_GAP;
        end else if (r_cnt == C_LAST) begin
          w_irq     = 1'b0;
          w_timeout = 1'b1;
          w_state   = ST_GAP;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      // One idle edge lets the upstream latch apply clear before enc_valid
      // is sampled again, preventing a re-issue of the serviced request.
      ST_GAP: begin
        w_state = ST_IDLE;
      end

      default: begin
        w_state = ST_IDLE;
        w_irq   = 1'b0;
      end
    endcase

    w_busy = (w_state != ST_IDLE);
  end

  assign bus.irq     = r_irq;
  assign bus.vector  = r_vector;
  assign bus.clear   = r_clear;
  assign bus.busy    = r_busy;
  assign bus.timeout = r_timeout;

`ifdef IRQ_SERVICE_COUNT_EN
  logic [7:0] r_serviced;

  // Advances together with the registered clear pulse, saturating at 8'hFF.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_serviced <= 8'h00;
    end else if ((w_clear != 4'b0000) && (r_serviced != 8'hFF)) begin
      r_serviced <= r_serviced + 8'h01;
    end
  end

  assign bus.serviced = r_serviced;
`endif

endmodule
`default_nettype wire

// File: tb/tb_irq_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_dispatcher
// Description : Directed self-checking bench for irq_dispatcher (TIMEOUT=15,
//               CW=4). Inputs change 1 time unit after a rising edge, and
//               outputs are checked at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_dispatcher;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  irq_dispatcher_if bus ();

  irq_dispatcher #(
    .TIMEOUT (15),
    .CW      (4)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".irq"},     {31'd0, bus.irq},     32'd0);
    check({tag, ".busy"},    {31'd0, bus.busy},    32'd0);
    check({tag, ".clear"},   {28'd0, bus.clear},   32'd0);
    check({tag, ".timeout"}, {31'd0, bus.timeout}, 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.enc_out   = 2'b00;
    bus.enc_valid = 1'b0;
    bus.ack       = 1'b0;

    // ---- reset state ----
    #1;
    check_idle("rst");
    check("rst.vector", {30'd0, bus.vector}, 32'd0);
`ifdef IRQ_SERVICE_COUNT_EN
    check("rst.serviced", {24'd0, bus.serviced}, 32'd0);
`endif
    tick();
    tick();
    rst = 1'b0;

    // ---- 1: idle with no requests ----
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle("idle");
    end

    // ---- 2: request 2, ack in third WAIT cycle ----
    bus.enc_out   = 2'b10;
    bus.enc_valid = 1'b1;
    tick();
    check("t2.irq0",    {31'd0, bus.irq},    32'd1);
    check("t2.vector0", {30'd0, bus.vector}, 32'd2);
    check("t2.busy0",   {31'd0, bus.busy},   32'd1);
    bus.enc_valid = 1'b0;
    tick();
    check("t2.irq1", {31'd0, bus.irq}, 32'd1);
    tick();
    check("t2.irq2",    {31'd0, bus.irq},    32'd1);
    check("t2.vector2", {30'd0, bus.vector}, 32'd2);
    bus.ack = 1'b1;
    tick();
    check("t2.irq_off",  {31'd0, bus.irq},     32'd0);
    check("t2.clear",    {28'd0, bus.clear},   32'h4);
    check("t2.busy_gap", {31'd0, bus.busy},    32'd1);
    check("t2.timeout",  {31'd0, bus.timeout}, 32'd0);
    bus.ack = 1'b0;
    tick();
    check_idle("t2.done");

    // ---- 3: request 1, never acknowledged ----
    bus.enc_out   = 2'b01;
    bus.enc_valid = 1'b1;
    tick();
    check("t3.irq0",    {31'd0, bus.irq},    32'd1);
    check("t3.vector0", {30'd0, bus.vector}, 32'd1);
    for (int i = 1; i < 15; i++) begin
      tick();
      check("t3.irq_held", {31'd0, bus.irq},     32'd1);
      check("t3.no_to",    {31'd0, bus.timeout}, 32'd0);
    end
    tick();
    check("t3.irq_off", {31'd0, bus.irq},     32'd0);
    check("t3.timeout", {31'd0, bus.timeout}, 32'd1);
    check("t3.clear",   {28'd0, bus.clear},   32'd0);
    check("t3.busy",    {31'd0, bus.busy},    32'd1);
    tick();
    check_idle("t3.idle");
    tick();
    check("t3.reissue",   {31'd0, bus.irq},    32'd1);
    check("t3.revector",  {30'd0, bus.vector}, 32'd1);
    bus.enc_valid = 1'b0;
    bus.ack       = 1'b1;
    tick();
    check("t3.clear_ack", {28'd0, bus.clear}, 32'h2);
    bus.ack = 1'b0;
    tick();
    check_idle("t3.done");

    // ---- 4: ack on the expiring cycle ----
    bus.enc_out   = 2'b11;
    bus.enc_valid = 1'b1;
    tick();
    check("t4.irq0", {31'd0, bus.irq}, 32'd1);
    bus.enc_valid = 1'b0;
    for (int i = 1; i < 15; i++) tick();
    check("t4.irq_last", {31'd0, bus.irq}, 32'd1);
    bus.ack = 1'b1;
    tick();
    check("t4.clear",   {28'd0, bus.clear},   32'h8);
    check("t4.timeout", {31'd0, bus.timeout}, 32'd0);
    check("t4.irq_off", {31'd0, bus.irq},     32'd0);
    bus.ack = 1'b0;
    tick();
    check_idle("t4.done");

    // ---- 5a: vector frozen while enc_out changes ----
    bus.enc_out   = 2'b11;
    bus.enc_valid = 1'b1;
    tick();
    check("t5.vector0", {30'd0, bus.vector}, 32'd3);
    bus.enc_out = 2'b00;
    tick();
    check("t5.vector1", {30'd0, bus.vector}, 32'd3);
    tick();
    check("t5.vector2", {30'd0, bus.vector}, 32'd3);
    bus.ack = 1'b1;
    tick();
    check("t5.clear", {28'd0, bus.clear}, 32'h8);
    bus.ack       = 1'b0;
    bus.enc_valid = 1'b0;
    tick();
    tick();
    check_idle("t5.idle");

    // ---- 5b: reset mid-WAIT ----
    bus.enc_out   = 2'b10;
    bus.enc_valid = 1'b1;
    tick();
    check("t5.irq_pre", {31'd0, bus.irq}, 32'd1);
    bus.enc_valid = 1'b0;
    tick();
    #3;
    rst = 1'b1;
    #1;
    check_idle("t5.abort");
    check("t5.abort_vec", {30'd0, bus.vector}, 32'd0);
    #1;
    rst = 1'b0;
    tick();
    check_idle("t5.after");
    tick();
    check_idle("t5.after2");

`ifdef IRQ_SERVICE_COUNT_EN
    // ---- 6: saturating service counter ----
    for (int i = 0; i < 300; i++) begin
      bus.enc_out   = 2'(i);
      bus.enc_valid = 1'b1;
      tick();
      bus.enc_valid = 1'b0;
      bus.ack       = 1'b1;
      tick();
      bus.ack = 1'b0;
      tick();
      if (i == 0) check("t6.first", {24'd0, bus.serviced}, 32'd1);
    end
    check("t6.sat", {24'd0, bus.serviced}, 32'hFF);
    #3;
    rst = 1'b1;
    #1;
    check("t6.rst", {24'd0, bus.serviced}, 32'd0);
    #1;
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
